// File: rtl/am_pkg.sv
// Shared constants and FSM state encoding for the approximate-multiplier error monitor.
package am_pkg;

  localparam int PROD_W = 16;
  localparam int DIFF_W = 17;
  localparam int SQ_PROD_W = 2 * PROD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/am_err_pipe.sv
// Two-stage datapath: S1 captures the exact product and z_approx, S2 holds |err| and |err|^2.
module am_err_pipe
  import am_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic [7:0]           x,
  input  logic [7:0]           y,
  input  logic [PROD_W-1:0]    z_approx,
  output logic                 s1_valid,
  output logic                 s2_valid,
  output logic [PROD_W-1:0]    abs_err,
  output logic [SQ_PROD_W-1:0] sq_err
);

  logic [PROD_W-1:0]    prod_reg;
  logic [PROD_W-1:0]    z_reg;
  logic                 s1_valid_reg;
  logic [PROD_W-1:0]    abs_reg;
  logic [SQ_PROD_W-1:0] sq_reg;
  logic                 s2_valid_reg;

  logic [DIFF_W-1:0]    diff_next;
  logic [DIFF_W-1:0]    neg_diff;
  logic [PROD_W-1:0]    abs_next;
  logic [SQ_PROD_W-1:0] sq_next;

  // diff is the signed 17-bit z_approx - exact; its magnitude always fits 16 bits
  always_comb begin
    diff_next = {1'b0, z_reg} - {1'b0, prod_reg};
    neg_diff  = -diff_next;
    abs_next  = diff_next[DIFF_W-1] ? neg_diff[PROD_W-1:0] : diff_next[PROD_W-1:0];
    sq_next   = {{PROD_W{1'b0}}, abs_next} * {{PROD_W{1'b0}}, abs_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg     <= '0;
      z_reg        <= '0;
      s1_valid_reg <= 1'b0;
      abs_reg      <= '0;
      sq_reg       <= '0;
      s2_valid_reg <= 1'b0;
    end else begin
      prod_reg     <= {8'b0, x} * {8'b0, y};
      z_reg        <= z_approx;
      s1_valid_reg <= accept;
      abs_reg      <= abs_next;
      sq_reg       <= sq_next;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  assign s1_valid = s1_valid_reg;
  assign s2_valid = s2_valid_reg;
  assign abs_err  = abs_reg;
  assign sq_err   = sq_reg;

endmodule

// File: rtl/am_error_monitor.sv
// Run controller and saturating error-statistics accumulators for approximate multipliers.
module am_error_monitor
  import am_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32,
  parameter int SQ_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [15:0]       z_approx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  samples,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [15:0]       max_abs_err,
  output logic [SUM_W-1:0]  sum_abs_err,
  output logic [SQ_W-1:0]   sum_sq_err
);

  state_t               state_reg;
  logic [CNT_W-1:0]     len_reg;
  logic [CNT_W-1:0]     samples_reg;
  logic [CNT_W-1:0]     err_cnt_reg;
  logic [PROD_W-1:0]    max_reg;
  logic [SUM_W-1:0]     sum_abs_reg;
  logic [SQ_W-1:0]      sum_sq_reg;
  logic                 in_ready_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic                 accept;
  logic                 s1_valid;
  logic                 s2_valid;
  logic [PROD_W-1:0]    abs_err;
  logic [SQ_PROD_W-1:0] sq_err;

  logic [CNT_W-1:0]     samples_inc;
  logic [SUM_W:0]       sum_abs_wide;
  logic [SQ_W:0]        sum_sq_wide;
  logic [SUM_W-1:0]     sum_abs_next;
  logic [SQ_W-1:0]      sum_sq_next;

  assign accept = in_valid & in_ready_reg;

  am_err_pipe u_pipe (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .x        (x),
    .y        (y),
    .z_approx (z_approx),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .abs_err  (abs_err),
    .sq_err   (sq_err)
  );

  // One extra carry bit detects overflow; once pinned at all-ones the sum stays there
  always_comb begin
    samples_inc  = samples_reg + CNT_W'(1);
    sum_abs_wide = {1'b0, sum_abs_reg} + (SUM_W+1)'(abs_err);
    sum_sq_wide  = {1'b0, sum_sq_reg} + (SQ_W+1)'(sq_err);
    sum_abs_next = sum_abs_wide[SUM_W] ? '1 : sum_abs_wide[SUM_W-1:0];
    sum_sq_next  = sum_sq_wide[SQ_W]   ? '1 : sum_sq_wide[SQ_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      samples_reg  <= '0;
      err_cnt_reg  <= '0;
      max_reg      <= '0;
      sum_abs_reg  <= '0;
      sum_sq_reg   <= '0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (s2_valid) begin
        err_cnt_reg <= err_cnt_reg + {{(CNT_W-1){1'b0}}, (abs_err != '0)};
        if (abs_err > max_reg) max_reg <= abs_err;
        sum_abs_reg <= sum_abs_next;
        sum_sq_reg  <= sum_sq_next;
      end
      case (state_reg)
        IDLE, DONE: begin
          // pipeline is empty here, so clearing overrides nothing in flight
          if (start) begin
            len_reg     <= cfg_len;
            samples_reg <= '0;
            err_cnt_reg <= '0;
            max_reg     <= '0;
            sum_abs_reg <= '0;
            sum_sq_reg  <= '0;
            if (cfg_len == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b1;
              busy_reg     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            samples_reg <= samples_inc;
            if (samples_inc == len_reg) begin
              state_reg    <= DRAIN;
              in_ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // S2 retires on this same edge, so leaving once S1 is empty lands 2 cycles after last accept
          if (!s1_valid) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign samples     = samples_reg;
  assign err_cnt     = err_cnt_reg;
  assign max_abs_err = max_reg;
  assign sum_abs_err = sum_abs_reg;
  assign sum_sq_err  = sum_sq_reg;

endmodule

// File: tb/tb_am_error_monitor.sv
// Directed checks of am_error_monitor: exact runs, error statistics, saturation, len=0, gaps, reset.
module tb_am_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] z_approx;

  logic        in_ready, busy, done;
  logic [15:0] samples, err_cnt, max_abs_err;
  logic [31:0] sum_abs_err;
  logic [47:0] sum_sq_err;

  logic        in_ready_s, busy_s, done_s;
  logic [15:0] samples_s, err_cnt_s, max_abs_err_s;
  logic [15:0] sum_abs_err_s;
  logic [47:0] sum_sq_err_s;

  am_error_monitor #(.CNT_W(16), .SUM_W(32), .SQ_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy), .done(done), .samples(samples), .err_cnt(err_cnt),
    .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err)
  );

  am_error_monitor #(.CNT_W(16), .SUM_W(16), .SQ_W(48)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_s), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy_s), .done(done_s), .samples(samples_s), .err_cnt(err_cnt_s),
    .max_abs_err(max_abs_err_s), .sum_abs_err(sum_abs_err_s), .sum_sq_err(sum_sq_err_s)
  );

  always #5 clk = ~clk;

  int     tests_run = 0;
  int     tests_failed = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     last_acc = 0;
  int     exp_err_cnt;
  int     exp_max;
  longint exp_sum;
  longint exp_sq;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    exp_err_cnt = 0;
    exp_max = 0;
    exp_sum = 0;
    exp_sq = 0;
  endtask

  task automatic model_add(input int xv, input int yv, input int zv);
    int d;
    d = zv - xv * yv;
    if (d < 0) d = -d;
    if (d != 0) exp_err_cnt++;
    if (d > exp_max) exp_max = d;
    exp_sum += d;
    exp_sq += longint'(d) * longint'(d);
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    cfg_len = 16'(len);
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input int xv, input int yv, input int zv);
    bit ok;
    ok = 1'b0;
    x = 8'(xv);
    y = 8'(yv);
    z_approx = 16'(zv);
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        last_acc = cyc;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'(ok), 64'd1);
    else model_add(xv, yv, zv);
  endtask

  task automatic wait_done(input int budget);
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != c0) break;
      tick();
    end
    check("done_seen", 64'(done_cnt - c0), 64'd1);
  endtask

  task automatic check_stats(input int exp_samples);
    check("samples", 64'(samples), 64'(exp_samples));
    check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    check("max_abs", 64'(max_abs_err), 64'(exp_max));
    check("sum_abs", 64'(sum_abs_err), 64'(exp_sum));
    check("sum_sq", 64'(sum_sq_err), 64'(exp_sq));
  endtask

  initial begin
    int xv, yv, zv, c0;
    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    x = '0; y = '0; z_approx = '0;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_stats(0);

    // exact multiplier stub, 256 samples
    do_start(256);
    check("run_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 256; i++) begin
      xv = int'($urandom_range(0, 255));
      yv = int'($urandom_range(0, 255));
      send(xv, yv, xv * yv);
    end
    wait_done(20);
    check("exact_samples", 64'(samples), 64'd256);
    check("exact_err_cnt", 64'(err_cnt), 64'd0);
    check("exact_max", 64'(max_abs_err), 64'd0);
    check("exact_sum", 64'(sum_abs_err), 64'd0);
    check("exact_sq", 64'(sum_sq_err), 64'd0);

    // worst-case single error
    do_start(1);
    send(255, 255, 0);
    wait_done(20);
    check("one_err_cnt", 64'(err_cnt), 64'd1);
    check("one_max", 64'(max_abs_err), 64'd65025);
    check("one_sum", 64'(sum_abs_err), 64'd65025);
    check("one_sq", 64'(sum_sq_err), 64'd4228250625);

    // start with in_valid high in DONE: sample must not be taken that cycle
    x = 8'd200; y = 8'd200; z_approx = 16'd0; in_valid = 1'b1;
    start = 1'b1; cfg_len = 16'd3;
    tick();
    start = 1'b0; in_valid = 1'b0;
    model_clear();
    check("startvld_samples", 64'(samples), 64'd0);
    check("startvld_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) send(200, 200, 0);
    wait_done(20);
    check("sat_sum16", 64'(sum_abs_err_s), 64'd65535);
    check("sat_max16", 64'(max_abs_err_s), 64'd40000);
    check("sat_sum32", 64'(sum_abs_err), 64'd120000);
    check("sat_sq", 64'(sum_sq_err), 64'd4800000000);
    check("sat_err_cnt", 64'(err_cnt), 64'd3);

    // empty run
    c0 = done_cnt;
    do_start(0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_ready", 64'(in_ready), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    check_stats(0);
    tick();
    check("len0_done_pulse", 64'(done), 64'd0);
    check("len0_ready2", 64'(in_ready), 64'd0);
    check("len0_done_cnt", 64'(done_cnt - c0), 64'd1);

    // gaps, ignored start during RUN, done latency
    do_start(10);
    for (int i = 0; i < 10; i++) begin
      xv = int'($urandom_range(0, 255));
      yv = int'($urandom_range(0, 255));
      zv = ($urandom_range(0, 1) == 1) ? xv * yv : int'($urandom_range(0, 65535));
      send(xv, yv, zv);
      if (i == 9) begin
        check("ready_drop", 64'(in_ready), 64'd0);
        check("drain_busy", 64'(busy), 64'd1);
      end else begin
        if (i == 4) begin
          start = 1'b1; cfg_len = 16'd3;
          tick();
          start = 1'b0;
        end
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    wait_done(20);
    check("done_latency", 64'(done_cyc - last_acc), 64'd2);
    check_stats(10);
    check("done_busy", 64'(busy), 64'd0);

    // reset mid-run
    c0 = done_cnt;
    do_start(20);
    for (int i = 0; i < 5; i++) send(i + 3, 7, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_ready", 64'(in_ready), 64'd0);
    check_stats(0);
    in_valid = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    check("rst_idle_samples", 64'(samples), 64'd0);
    check("rst_no_done", 64'(done_cnt - c0), 64'd0);
    check("rst_idle_sum", 64'(sum_abs_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
